// File: rtl/riscv_wb_stage.sv
// Write-back stage for loads: waits for LSU data, aligns and extends it, and writes the
// register file (data plus DIFT tag) one cycle later. Flushed or overdue loads are dropped.
module riscv_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    output logic        wb_ready_o,
    input  logic        regfile_we_i,
    input  logic [4:0]  regfile_waddr_i,
    input  logic [1:0]  data_type_i,
    input  logic        data_sign_ext_i,
    input  logic [1:0]  data_reg_offset_i,
    input  logic        flush_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic        lsu_rdata_tag_i,
    input  logic        lsu_rvalid_i,
    output logic        regfile_we_o,
    output logic [4:0]  regfile_waddr_o,
    output logic [31:0] regfile_wdata_o,
    output logic        regfile_wdata_o_tag,
    output logic        regfile_we_o_tag,
    output logic        timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [4:0]  pend_waddr;
    logic [1:0]  pend_type;
    logic        pend_sign_ext;
    logic [1:0]  pend_offset;
    logic        accept;
    logic        complete;
    logic        expired;
    logic [31:0] rot;
    logic [31:0] aligned;

    assign accept   = ex_valid_i & wb_ready_o;
    assign complete = (state == S_WAIT) & lsu_rvalid_i;
    // rvalid wins over an expiring counter, so a late-but-on-time load still completes.
    assign expired  = (state != S_IDLE) & ~lsu_rvalid_i & (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults at the top of every always_comb keep all paths assigned, so no latches.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (accept && regfile_we_i) begin
                    state_next = S_WAIT;
                    cnt_next   = 8'd0;
                end
            end
            S_WAIT: begin
                if (lsu_rvalid_i) begin
                    state_next = (accept && regfile_we_i) ? S_WAIT : S_IDLE;
                    cnt_next   = 8'd0;
                end else if (expired) begin
                    state_next = S_IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    state_next = flush_i ? S_DROP : S_WAIT;
                    cnt_next   = cnt + 8'd1;
                end
            end
            S_DROP: begin
                if (lsu_rvalid_i || expired) begin
                    state_next = S_IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next   = cnt + 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    always_comb begin
        wb_ready_o = ((state == S_IDLE) | complete) & ~flush_i;
        timeout_o  = expired;
    end

    always_comb begin
        case (pend_offset)
            2'd1:    rot = {lsu_rdata_i[7:0],  lsu_rdata_i[31:8]};
            2'd2:    rot = {lsu_rdata_i[15:0], lsu_rdata_i[31:16]};
            2'd3:    rot = {lsu_rdata_i[23:0], lsu_rdata_i[31:24]};
            default: rot = lsu_rdata_i;
        endcase
        case (pend_type)
            2'b01:   aligned = {{16{pend_sign_ext & rot[15]}}, rot[15:0]};
            2'b10:   aligned = {{24{pend_sign_ext & rot[7]}},  rot[7:0]};
            default: aligned = rot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_waddr          <= 5'd0;
            pend_type           <= 2'd0;
            pend_sign_ext       <= 1'b0;
            pend_offset         <= 2'd0;
            regfile_we_o        <= 1'b0;
            regfile_waddr_o     <= 5'd0;
            regfile_wdata_o     <= 32'd0;
            regfile_wdata_o_tag <= 1'b0;
        end else begin
            if (accept) begin
                pend_waddr    <= regfile_waddr_i;
                pend_type     <= data_type_i;
                pend_sign_ext <= data_sign_ext_i;
                pend_offset   <= data_reg_offset_i;
            end
            regfile_we_o <= complete;
            if (complete) begin
                regfile_waddr_o     <= pend_waddr;
                regfile_wdata_o     <= aligned;
                regfile_wdata_o_tag <= lsu_rdata_tag_i;
            end
        end
    end

    assign regfile_we_o_tag = regfile_we_o;

endmodule
